unified_mem_arbiter: RTL and testbench

- Sequences the single unified instruction/data memory port between the IF stage (fetch) and the MEM stage (load/store).
- Drives the memory command, returns read data to the winning requester, and generates per-requester stall.
- Sits between the pipeline stages and the Memory block. Replaces the direct PC/ALU-address hookup to memory.

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_arb_perf_cnt.sv | 17 +
 rtl/unified_mem_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 489 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    WAIT,
    ACK
  } arb_state_t;

  typedef enum logic {
    GNT_FETCH,
    GNT_DATA
  } grant_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam int LAT_CNT_W = 4;

endpackage

// File: rtl/mem_arb_perf_cnt.sv
// 32-bit saturating event counter used for the arbiter's stall statistics.
module mem_arb_perf_cnt (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  output logic [31:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != 32'hFFFF_FFFF)) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store, data first with anti-starvation.
// Define ARB_PERF_CNT_EN to add saturating stall-cycle counters on extra output ports.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W          = 8,
  parameter int MEM_LATENCY     = 1,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_ack,
  output logic [31:0]       if_rdata,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [31:0]       dm_wdata,
  input  logic [2:0]        dm_func3,
  output logic              dm_ack,
  output logic [31:0]       dm_rdata,
  output logic              dm_stall,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [2:0]        mem_func3,
  input  logic [31:0]       mem_rdata
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_if_stall_cyc,
  output logic [31:0]       perf_dm_stall_cyc
`endif
);

  localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 2);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);
  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(MEM_LATENCY);
  localparam logic [LAT_CNT_W-1:0] LAT_ONE  = LAT_CNT_W'(1);

  arb_state_t           state;
  arb_state_t           state_next;
  grant_t               grant_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [31:0]          wdata_q;
  logic [2:0]           func3_q;
  logic                 we_q;
  logic                 flushed_q;
  logic [LAT_CNT_W-1:0] lat_cnt;
  logic [STREAK_W-1:0]  streak;
  logic [31:0]          if_rdata_q;
  logic [31:0]          dm_rdata_q;

  logic fetch_cand;
  logic any_cand;
  logic fetch_wins;
  logic fetch_killed;
  logic lat_done;

  // A flushed fetch drops its candidacy for this cycle; a waiting fetch is forced once the data streak is full.
  assign fetch_cand   = if_req & ~if_flush;
  assign any_cand     = fetch_cand | dm_req;
  assign fetch_wins   = fetch_cand & (~dm_req | (streak == STREAK_MAX));
  assign fetch_killed = (grant_q == GNT_FETCH) & (flushed_q | if_flush);
  assign lat_done     = (lat_cnt == LAT_ONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_cand) state_next = CMD;
      CMD:     state_next = WAIT;
      WAIT:    if (lat_done) state_next = fetch_killed ? IDLE : ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if_ack    = 1'b0;
    dm_ack    = 1'b0;
    if (!reset) begin
      case (state)
        CMD: begin
          mem_read  = ~we_q;
          mem_write = we_q;
        end
        ACK: begin
          if_ack = (grant_q == GNT_FETCH);
          dm_ack = (grant_q == GNT_DATA);
        end
        default: ;
      endcase
    end
  end

  // Command latch, latency countdown, flush tracking and read-data capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_q    <= GNT_FETCH;
      addr_q     <= '0;
      wdata_q    <= '0;
      func3_q    <= '0;
      we_q       <= 1'b0;
      flushed_q  <= 1'b0;
      lat_cnt    <= '0;
      streak     <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_cand) begin
            flushed_q <= 1'b0;
            if (fetch_wins) begin
              grant_q <= GNT_FETCH;
              addr_q  <= if_addr;
              wdata_q <= '0;
              func3_q <= F3_LW;
              we_q    <= 1'b0;
              streak  <= '0;
            end else begin
              grant_q <= GNT_DATA;
              addr_q  <= dm_addr;
              wdata_q <= dm_wdata;
              func3_q <= dm_func3;
              we_q    <= dm_we;
              if (!if_req) begin
                streak <= '0;
              end else if (streak != STREAK_MAX) begin
                streak <= streak + STREAK_W'(1);
              end
            end
          end
        end
        CMD: begin
          lat_cnt <= LAT_LOAD;
          if ((grant_q == GNT_FETCH) && if_flush) flushed_q <= 1'b1;
        end
        WAIT: begin
          if ((grant_q == GNT_FETCH) && if_flush) flushed_q <= 1'b1;
          if (lat_done) begin
            if (grant_q == GNT_FETCH) begin
              if (!fetch_killed) if_rdata_q <= mem_rdata;
            end else if (!we_q) begin
              dm_rdata_q <= mem_rdata;
            end
          end else begin
            lat_cnt <= lat_cnt - LAT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_stall  = if_req & ~if_ack;
  assign dm_stall  = dm_req & ~dm_ack;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_func3 = func3_q;

`ifdef ARB_PERF_CNT_EN
  mem_arb_perf_cnt u_if_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (if_stall),
    .count (perf_if_stall_cyc)
  );

  mem_arb_perf_cnt u_dm_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (dm_stall),
    .count (perf_dm_stall_cyc)
  );
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_unified_mem_arbiter;

  localparam int LAT = 1;
  localparam int MAX_STREAK = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, if_req, if_flush, dm_req, dm_we;
  logic [7:0]  if_addr, dm_addr;
  logic [31:0] dm_wdata;
  logic [2:0]  dm_func3;

  logic        if_ack, if_stall, dm_ack, dm_stall, mem_read, mem_write;
  logic [31:0] if_rdata, dm_rdata, mem_wdata, mem_rdata;
  logic [7:0]  mem_addr;
  logic [2:0]  mem_func3;

  logic        if_ack3, if_stall3, dm_ack3, dm_stall3, mem_read3, mem_write3;
  logic [31:0] if_rdata3, dm_rdata3, mem_wdata3, mem_rdata3;
  logic [7:0]  mem_addr3;
  logic [2:0]  mem_func33;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_if, perf_dm, perf_if3, perf_dm3;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [31:0] cyc = '0;
  logic [31:0] bmem [256];
  logic [31:0] bmem3 [256];
  logic [31:0] ref_mem [256];
  logic [31:0] p1, p2;
  logic [31:0] exp_if_rdata, exp_dm_rdata;

  unified_mem_arbiter #(.ADDR_W(8), .MEM_LATENCY(LAT), .MAX_DATA_STREAK(MAX_STREAK)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_ack(if_ack), .if_rdata(if_rdata), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_func3(dm_func3),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_func3(mem_func3), .mem_rdata(mem_rdata)
`ifdef ARB_PERF_CNT_EN
    , .perf_if_stall_cyc(perf_if), .perf_dm_stall_cyc(perf_dm)
`endif
  );

  unified_mem_arbiter #(.ADDR_W(8), .MEM_LATENCY(3), .MAX_DATA_STREAK(MAX_STREAK)) dut3 (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_ack(if_ack3), .if_rdata(if_rdata3), .if_stall(if_stall3),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_func3(dm_func3),
    .dm_ack(dm_ack3), .dm_rdata(dm_rdata3), .dm_stall(dm_stall3),
    .mem_read(mem_read3), .mem_write(mem_write3), .mem_addr(mem_addr3),
    .mem_wdata(mem_wdata3), .mem_func3(mem_func33), .mem_rdata(mem_rdata3)
`ifdef ARB_PERF_CNT_EN
    , .perf_if_stall_cyc(perf_if3), .perf_dm_stall_cyc(perf_dm3)
`endif
  );

  function automatic logic [31:0] init_word(int i);
    if (i == 16) return 32'h0050_0093;
    return 32'hC0DE_0000 ^ (32'(i) * 32'h0001_0203);
  endfunction

  // Memory models: data is valid only in the cycle exactly LAT cycles after the command.
  always @(posedge clk) begin
    cyc <= cyc + 32'd1;
    if (reset) begin
      for (int i = 0; i < 256; i++) bmem[i] <= init_word(i);
    end else if (mem_write) begin
      bmem[mem_addr] <= mem_wdata;
    end
    mem_rdata <= mem_read ? bmem[mem_addr] : (32'hBAD0_0000 ^ cyc);
  end

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) bmem3[i] <= init_word(i);
    end else if (mem_write3) begin
      bmem3[mem_addr3] <= mem_wdata3;
    end
    p1 <= mem_read3 ? bmem3[mem_addr3] : (32'hBAD3_0000 ^ cyc);
    p2 <= p1;
    mem_rdata3 <= p2;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic sample;
    @(negedge clk);
  endtask

  task automatic clear_inputs;
    if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_func3 = '0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    clear_inputs();
    repeat (2) step();
    reset = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    exp_if_rdata = '0;
    exp_dm_rdata = '0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    if_req = 1'b1; if_addr = 8'hFF; dm_req = 1'b1; dm_we = 1'b1; dm_addr = 8'hAA;
    dm_wdata = 32'h1234_5678; dm_func3 = 3'b010;
    repeat (2) step();
    sample();
    checks++;
    if ({mem_read, mem_write, if_ack, dm_ack} !== 4'b0000)
      $display("[TB] FAIL reset_strobes: got %b expected 0000", {mem_read, mem_write, if_ack, dm_ack});
    checks++;
    if ({mem_addr, mem_func3, mem_wdata} !== 43'd0)
      $display("[TB] FAIL reset_cmd: got %h/%h/%h expected 0", mem_addr, mem_func3, mem_wdata);
    checks++;
    if ({if_rdata, dm_rdata} !== 64'd0)
      $display("[TB] FAIL reset_rdata: got %h/%h expected 0", if_rdata, dm_rdata);
    checks++;
    if ({if_stall, dm_stall} !== 2'b11)
      $display("[TB] FAIL reset_stall: got %b expected 11", {if_stall, dm_stall});
    errors += (({mem_read, mem_write, if_ack, dm_ack} !== 4'b0000) ? 1 : 0)
            + (({mem_addr, mem_func3, mem_wdata} !== 43'd0) ? 1 : 0)
            + (({if_rdata, dm_rdata} !== 64'd0) ? 1 : 0)
            + (({if_stall, dm_stall} !== 2'b11) ? 1 : 0);
    step();
    reset = 1'b0;
    clear_inputs();
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    exp_if_rdata = '0;
    exp_dm_rdata = '0;
  endtask

  task automatic test_single_fetch;
    if_req = 1'b1; if_addr = 8'h10;
    for (int k = 0; k < 4; k++) begin
      sample();
      checks++;
      if (mem_read !== (k == 1)) begin
        errors++; $display("[TB] FAIL fetch_mem_read k=%0d: got %b expected %b", k, mem_read, k == 1);
      end
      if (k == 1) begin
        checks++;
        if ({mem_addr, mem_func3} !== {8'h10, 3'b010}) begin
          errors++; $display("[TB] FAIL fetch_cmd: got %h/%b expected 10/010", mem_addr, mem_func3);
        end
      end
      checks++;
      if (if_ack !== (k == 3)) begin
        errors++; $display("[TB] FAIL fetch_ack k=%0d: got %b expected %b", k, if_ack, k == 3);
      end
      checks++;
      if (if_stall !== (k != 3)) begin
        errors++; $display("[TB] FAIL fetch_stall k=%0d: got %b expected %b", k, if_stall, k != 3);
      end
      if (k == 3) begin
        exp_if_rdata = 32'h0050_0093;
        checks++;
        if (if_rdata !== exp_if_rdata) begin
          errors++; $display("[TB] FAIL fetch_rdata: got %h expected %h", if_rdata, exp_if_rdata);
        end
      end
      step();
    end
    if_req = 1'b0;
  endtask

  task automatic test_simultaneous;
    if_req = 1'b1; if_addr = 8'h20;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 8'h40; dm_func3 = 3'b010;
    for (int k = 0; k < 8; k++) begin
      sample();
      checks++;
      if (mem_read !== (k == 1 || k == 5)) begin
        errors++; $display("[TB] FAIL simul_mem_read k=%0d: got %b", k, mem_read);
      end
      if (k == 1) begin
        checks++;
        if (mem_addr !== 8'h40) begin
          errors++; $display("[TB] FAIL simul_data_addr: got %h expected 40", mem_addr);
        end
      end
      if (k == 5) begin
        checks++;
        if ({mem_addr, mem_func3} !== {8'h20, 3'b010}) begin
          errors++; $display("[TB] FAIL simul_fetch_cmd: got %h/%b expected 20/010", mem_addr, mem_func3);
        end
      end
      checks++;
      if ({if_ack, dm_ack} !== {k == 7, k == 3}) begin
        errors++; $display("[TB] FAIL simul_acks k=%0d: got %b expected %b", k, {if_ack, dm_ack}, {k == 7, k == 3});
      end
      checks++;
      if ({if_stall, dm_stall} !== {k < 7, k < 3}) begin
        errors++; $display("[TB] FAIL simul_stalls k=%0d: got %b expected %b", k, {if_stall, dm_stall}, {k < 7, k < 3});
      end
      if (k == 3) begin
        exp_dm_rdata = ref_mem[8'h40];
        checks++;
        if (dm_rdata !== exp_dm_rdata) begin
          errors++; $display("[TB] FAIL simul_dm_rdata: got %h expected %h", dm_rdata, exp_dm_rdata);
        end
      end
      if (k == 7) begin
        exp_if_rdata = ref_mem[8'h20];
        checks++;
        if (if_rdata !== exp_if_rdata) begin
          errors++; $display("[TB] FAIL simul_if_rdata: got %h expected %h", if_rdata, exp_if_rdata);
        end
      end
      step();
      if (k == 3) dm_req = 1'b0;
    end
    if_req = 1'b0;
  endtask

  // Every fifth grant must go to the waiting fetch; each transaction occupies four cycles.
  task automatic test_starvation;
    int  nack;
    logic ia, da;
    nack = 0;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 8'h80; dm_func3 = 3'b000;
    if_req = 1'b1; if_addr = 8'h30;
    for (int k = 0; k < 60 && nack < 10; k++) begin
      sample();
      ia = if_ack; da = dm_ack;
      if (ia || da) begin
        checks++;
        if (k != 4 * nack + 3) begin
          errors++; $display("[TB] FAIL starve_timing ack#%0d: got cycle %0d expected %0d", nack, k, 4 * nack + 3);
        end
        checks++;
        if ({ia, da} !== (((nack % 5) == 4) ? 2'b10 : 2'b01)) begin
          errors++; $display("[TB] FAIL starve_order ack#%0d: got %b expected %b", nack, {ia, da},
                              ((nack % 5) == 4) ? 2'b10 : 2'b01);
        end
        nack++;
      end
      step();
      if (da) dm_addr = dm_addr + 8'd4;
      if (ia) if_addr = if_addr + 8'd4;
    end
    checks++;
    if (nack != 10) begin
      errors++; $display("[TB] FAIL starve_budget: got %0d acks expected 10", nack);
    end
    if_req = 1'b0;
    dm_req = 1'b0;
  endtask

  task automatic test_flush;
    // Flush in IDLE delays the grant by one cycle.
    if_req = 1'b1; if_addr = 8'h44; if_flush = 1'b1;
    for (int k = 0; k < 5; k++) begin
      sample();
      checks++;
      if (mem_read !== (k == 2)) begin
        errors++; $display("[TB] FAIL flush_idle_read k=%0d: got %b expected %b", k, mem_read, k == 2);
      end
      checks++;
      if (if_ack !== (k == 4)) begin
        errors++; $display("[TB] FAIL flush_idle_ack k=%0d: got %b expected %b", k, if_ack, k == 4);
      end
      if (k == 4) begin
        exp_if_rdata = ref_mem[8'h44];
        checks++;
        if (if_rdata !== exp_if_rdata) begin
          errors++; $display("[TB] FAIL flush_idle_rdata: got %h expected %h", if_rdata, exp_if_rdata);
        end
      end
      step();
      if_flush = 1'b0;
    end
    if_req = 1'b0;
    step();
    // Flush in WAIT: read completes, no ack, rdata kept, arbiter free next cycle.
    if_req = 1'b1; if_addr = 8'h48;
    for (int k = 0; k < 8; k++) begin
      sample();
      checks++;
      if (mem_read !== (k == 1 || k == 4)) begin
        errors++; $display("[TB] FAIL flush_wait_read k=%0d: got %b", k, mem_read);
      end
      if (k == 4) begin
        checks++;
        if (mem_addr !== 8'h4C) begin
          errors++; $display("[TB] FAIL flush_next_addr: got %h expected 4c", mem_addr);
        end
      end
      checks++;
      if ({if_ack, dm_ack} !== {1'b0, k == 6}) begin
        errors++; $display("[TB] FAIL flush_wait_acks k=%0d: got %b expected %b", k, {if_ack, dm_ack}, {1'b0, k == 6});
      end
      checks++;
      if (if_rdata !== exp_if_rdata) begin
        errors++; $display("[TB] FAIL flush_wait_rdata k=%0d: got %h expected %h", k, if_rdata, exp_if_rdata);
      end
      step();
      if (k == 1) if_flush = 1'b1;
      if (k == 2) begin
        if_flush = 1'b0; if_req = 1'b0;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 8'h4C; dm_func3 = 3'b010;
      end
      if (k == 6) dm_req = 1'b0;
    end
    exp_dm_rdata = ref_mem[8'h4C];
  endtask

  task automatic test_store_reset;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 8'h50; dm_wdata = 32'hDEAD_BEEF; dm_func3 = 3'b010;
    sample();
    checks++;
    if (mem_write !== 1'b0) begin
      errors++; $display("[TB] FAIL store_idle_write: got %b expected 0", mem_write);
    end
    step();
    reset = 1'b1;
    dm_req = 1'b0;
    sample();
    checks++;
    if (mem_write !== 1'b0) begin
      errors++; $display("[TB] FAIL store_cmd_reset_write: got %b expected 0", mem_write);
    end
    step();
    reset = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    exp_if_rdata = '0;
    exp_dm_rdata = '0;
    sample();
    checks++;
    if ({mem_read, mem_write, if_ack, dm_ack, mem_addr, mem_wdata, mem_func3, if_rdata, dm_rdata} !== 111'd0) begin
      errors++; $display("[TB] FAIL store_reset_outputs: got w=%b ack=%b addr=%h wdata=%h expected all 0",
                         mem_write, dm_ack, mem_addr, mem_wdata);
    end
    step();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 8'h54; dm_func3 = 3'b010;
    for (int k = 0; k < 5; k++) begin
      sample();
      checks++;
      if ({mem_read, mem_write, dm_ack} !== {k == 1, 1'b0, k == 3}) begin
        errors++; $display("[TB] FAIL store_reset_after k=%0d: got %b expected %b", k,
                           {mem_read, mem_write, dm_ack}, {k == 1, 1'b0, k == 3});
      end
      if (k == 3) begin
        exp_dm_rdata = ref_mem[8'h54];
        checks++;
        if (dm_rdata !== exp_dm_rdata) begin
          errors++; $display("[TB] FAIL store_reset_load: got %h expected %h", dm_rdata, exp_dm_rdata);
        end
      end
      step();
      if (k == 3) dm_req = 1'b0;
    end
  endtask

  task automatic test_latency3;
    do_reset();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 8'h60; dm_func3 = 3'b010;
    for (int k = 0; k < 7; k++) begin
      sample();
      checks++;
      if ({mem_read3, dm_ack3, dm_stall3} !== {k == 1, k == 5, k < 5}) begin
        errors++; $display("[TB] FAIL lat3 k=%0d: got rd/ack/stall=%b expected %b", k,
                           {mem_read3, dm_ack3, dm_stall3}, {k == 1, k == 5, k < 5});
      end
      if (k == 5) begin
        checks++;
        if (dm_rdata3 !== ref_mem[8'h60]) begin
          errors++; $display("[TB] FAIL lat3_rdata: got %h expected %h", dm_rdata3, ref_mem[8'h60]);
        end
      end
`ifdef ARB_PERF_CNT_EN
      if (k == 6) begin
        checks++;
        if ({perf_dm3, perf_if3} !== {32'd5, 32'd0}) begin
          errors++; $display("[TB] FAIL lat3_perf: got dm=%0d if=%0d expected dm=5 if=0", perf_dm3, perf_if3);
        end
      end
`endif
      step();
      if (k == 5) dm_req = 1'b0;
    end
  endtask

  // Transaction-level model: a grant occupies LAT+3 cycles, command one cycle later, ack at LAT+2.
  task automatic test_random;
    int   next_free, streak_m, cmd_at, ack_at;
    logic g_fetch, g_we, exp_ia, exp_da, seen_ia, seen_da;
    logic [7:0]  g_addr;
    logic [31:0] g_wdata, g_exp;
    logic [2:0]  g_f3;
    do_reset();
    next_free = 0; streak_m = 0; cmd_at = -1; ack_at = -1;
    g_fetch = 1'b0; g_we = 1'b0; g_addr = '0; g_wdata = '0; g_exp = '0; g_f3 = '0;
    seen_ia = 1'b0; seen_da = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (seen_ia) if_req = 1'b0;
      if (seen_da) dm_req = 1'b0;
      if (!if_req && n < 360 && $urandom_range(0, 3) != 0) begin
        if_req = 1'b1; if_addr = 8'($urandom_range(0, 63)) << 2;
      end
      if (!dm_req && n < 360 && $urandom_range(0, 2) != 0) begin
        dm_req = 1'b1; dm_we = 1'($urandom_range(0, 1)); dm_addr = 8'($urandom_range(0, 255));
        dm_wdata = $urandom; dm_func3 = 3'($urandom_range(0, 5));
      end
      if (n >= next_free && (if_req || dm_req)) begin
        g_fetch = if_req && (!dm_req || streak_m >= MAX_STREAK);
        if (g_fetch || !if_req) streak_m = 0;
        else if (streak_m < MAX_STREAK) streak_m++;
        if (g_fetch) begin
          g_addr = if_addr; g_f3 = 3'b010; g_we = 1'b0; g_wdata = '0; g_exp = ref_mem[if_addr];
        end else begin
          g_addr = dm_addr; g_f3 = dm_func3; g_we = dm_we; g_wdata = dm_wdata;
          if (dm_we) ref_mem[dm_addr] = dm_wdata;
          else g_exp = ref_mem[dm_addr];
        end
        cmd_at = n + 1; ack_at = n + 2 + LAT; next_free = n + 3 + LAT;
      end
      exp_ia = (n == ack_at) && g_fetch;
      exp_da = (n == ack_at) && !g_fetch;
      sample();
      checks++;
      if ({mem_read, mem_write} !== {n == cmd_at && !g_we, n == cmd_at && g_we}) begin
        errors++; $display("[TB] FAIL rnd_strobes n=%0d: got %b expected %b", n, {mem_read, mem_write},
                           {n == cmd_at && !g_we, n == cmd_at && g_we});
      end
      if (n == cmd_at) begin
        checks++;
        if ({mem_addr, mem_func3} !== {g_addr, g_f3} || (g_we && mem_wdata !== g_wdata)) begin
          errors++; $display("[TB] FAIL rnd_cmd n=%0d: got %h/%b/%h expected %h/%b/%h", n,
                             mem_addr, mem_func3, mem_wdata, g_addr, g_f3, g_wdata);
        end
      end
      checks++;
      if ({if_ack, dm_ack, if_stall, dm_stall} !== {exp_ia, exp_da, if_req & ~exp_ia, dm_req & ~exp_da}) begin
        errors++; $display("[TB] FAIL rnd_ack_stall n=%0d: got %b expected %b", n, {if_ack, dm_ack, if_stall, dm_stall},
                           {exp_ia, exp_da, if_req & ~exp_ia, dm_req & ~exp_da});
      end
      if (exp_ia) exp_if_rdata = g_exp;
      if (exp_da && !g_we) exp_dm_rdata = g_exp;
      if (exp_ia || exp_da) begin
        checks++;
        if ({if_rdata, dm_rdata} !== {exp_if_rdata, exp_dm_rdata}) begin
          errors++; $display("[TB] FAIL rnd_rdata n=%0d: got %h/%h expected %h/%h", n, if_rdata, dm_rdata,
                             exp_if_rdata, exp_dm_rdata);
        end
      end
      seen_ia = exp_ia;
      seen_da = exp_da;
      step();
    end
    clear_inputs();
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    exp_if_rdata = '0;
    exp_dm_rdata = '0;
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_starvation();
    test_flush();
    test_store_reset();
    test_latency3();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
